// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner: FSM states, frame
// results, index widths and small column-decoding helpers.
package keypad_pkg;

    localparam int ROW_W                  = 2;
    localparam int COL_W                  = 2;
    localparam int CODE_W                 = ROW_W + COL_W;
    localparam int CNT_W                  = 4;
    localparam int DEBOUNCE_SCANS_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_ONE   = 2'd1,
        RES_MULTI = 2'd2
    } result_t;

    // Number of active columns, saturated at 2 ("two or more").
    function automatic logic [1:0] active_count(input logic [3:0] v);
        logic [2:0] n;
        n = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
        return (n >= 3'd2) ? 2'd2 : n[1:0];
    endfunction

    // Column index with cols[3] as index 0; only meaningful for a single bit set.
    function automatic logic [COL_W-1:0] col_index(input logic [3:0] v);
        logic [COL_W-1:0] idx;
        idx = '0;
        if (v[3])      idx = 2'd0;
        else if (v[2]) idx = 2'd1;
        else if (v[1]) idx = 2'd2;
        else if (v[0]) idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/col_sync.sv
// Two-flop synchronizer for the asynchronous keypad column lines.
module col_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk_1,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge clk_1) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_reader.sv
// 4x4 keypad reader: aligns swept rows with synchronized columns, reduces
// each sweep to a NONE/ONE/MULTI frame result, and debounces press/release.
//
// state         | meaning
// --------------+-----------------------------------------------------
// ST_IDLE       | no key accepted, waiting for a single-key frame
// ST_PRESS_DB   | candidate seen, counting identical frames to accept
// ST_HELD       | key accepted, key_held asserted
// ST_RELEASE_DB | key still held, counting non-matching frames to drop
module keypad_reader
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEFAULT
) (
    input  logic              clk_1,
    input  logic              rst,
    input  logic [3:0]        rows,
    input  logic [3:0]        cols,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held,
    output logic              multi_key
);

    localparam logic [CNT_W-1:0] DB_CNT  = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [3:0]        cols_s;
    logic [3:0]        row_d1, row_d2;
    logic              row_ok;
    logic [ROW_W-1:0]  row_idx;
    logic              frame_start, frame_close, in_frame;
    logic [1:0]        acc_n, base_n, phase_n, tot_n;
    logic [2:0]        sum_n;
    logic [CODE_W-1:0] acc_code, base_code, phase_code, tot_code;
    result_t           result;
    state_t            state_q, state_n;
    logic [CNT_W-1:0]  count_q, count_n, cnt_inc;
    logic [CODE_W-1:0] cand_q, cand_n;
    logic              accept, hit_cand, hit_key;

    col_sync #(.WIDTH(4)) u_col_sync (
        .clk_1 (clk_1),
        .rst   (rst),
        .d     (cols),
        .q     (cols_s)
    );

    // Delay rows to match the synchronizer latency on cols.
    always_ff @(posedge clk_1) begin
        if (rst) begin
            row_d1 <= '0;
            row_d2 <= '0;
        end else begin
            row_d1 <= rows;
            row_d2 <= row_d1;
        end
    end

    // Decode the aligned row; anything not one-hot (0000, X) is ignored.
    always_comb begin
        row_ok  = 1'b1;
        row_idx = '0;
        case (row_d2)
            4'b1000: row_idx = 2'd0;
            4'b0100: row_idx = 2'd1;
            4'b0010: row_idx = 2'd2;
            4'b0001: row_idx = 2'd3;
            default: row_ok  = 1'b0;
        endcase
    end

    // Merge this phase into the running frame tally and classify at close.
    always_comb begin
        frame_start = row_ok && (row_idx == 2'd0);
        frame_close = row_ok && (row_idx == 2'd3) && in_frame;
        phase_n     = active_count(cols_s);
        phase_code  = {row_idx, col_index(cols_s)};
        base_n      = frame_start ? 2'd0 : acc_n;
        base_code   = frame_start ? '0 : acc_code;
        sum_n       = {1'b0, base_n} + {1'b0, phase_n};
        tot_n       = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
        tot_code    = (base_n == 2'd0) ? phase_code : base_code;
        result      = RES_NONE;
        if (tot_n == 2'd1)      result = RES_ONE;
        else if (tot_n == 2'd2) result = RES_MULTI;
    end

    // Frame accumulator; a frame only exists once an aligned 1000 is seen.
    always_ff @(posedge clk_1) begin
        if (rst) begin
            in_frame <= 1'b0;
            acc_n    <= '0;
            acc_code <= '0;
        end else if (row_ok && (frame_start || in_frame)) begin
            if (frame_close) begin
                in_frame <= 1'b0;
                acc_n    <= '0;
                acc_code <= '0;
            end else begin
                in_frame <= 1'b1;
                acc_n    <= tot_n;
                acc_code <= tot_code;
            end
        end
    end

    // Debounce FSM next-state; only advances on frame close.
    always_comb begin
        state_n  = state_q;
        count_n  = count_q;
        cand_n   = cand_q;
        accept   = 1'b0;
        cnt_inc  = (count_q == CNT_MAX) ? CNT_MAX : count_q + 1'b1;
        hit_cand = (result == RES_ONE) && (tot_code == cand_q);
        hit_key  = (result == RES_ONE) && (tot_code == key_code);
        if (frame_close) begin
            case (state_q)
                ST_IDLE: begin
                    if (result == RES_ONE) begin
                        cand_n  = tot_code;
                        count_n = 4'd1;
                        if (DB_CNT <= 4'd1) begin
                            state_n = ST_HELD;
                            accept  = 1'b1;
                        end else begin
                            state_n = ST_PRESS_DB;
                        end
                    end
                end
                ST_PRESS_DB: begin
                    if (hit_cand) begin
                        count_n = cnt_inc;
                        if (cnt_inc >= DB_CNT) begin
                            state_n = ST_HELD;
                            accept  = 1'b1;
                        end
                    end else if (result == RES_ONE) begin
                        cand_n  = tot_code;
                        count_n = 4'd1;
                    end else begin
                        state_n = ST_IDLE;
                        count_n = '0;
                    end
                end
                ST_HELD: begin
                    if (!hit_key) begin
                        if (DB_CNT <= 4'd1) begin
                            state_n = ST_IDLE;
                            count_n = '0;
                        end else begin
                            state_n = ST_RELEASE_DB;
                            count_n = 4'd1;
                        end
                    end
                end
                ST_RELEASE_DB: begin
                    if (hit_key) begin
                        state_n = ST_HELD;
                    end else begin
                        count_n = cnt_inc;
                        if (cnt_inc >= DB_CNT) begin
                            state_n = ST_IDLE;
                            count_n = '0;
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_1) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            cand_q    <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            multi_key <= 1'b0;
        end else begin
            state_q   <= state_n;
            count_q   <= count_n;
            cand_q    <= cand_n;
            if (accept) key_code <= tot_code;
            key_valid <= accept;
            key_held  <= (state_n == ST_HELD) || (state_n == ST_RELEASE_DB);
            multi_key <= frame_close && (result == RES_MULTI);
        end
    end

endmodule
